id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that feeds the 16-bit execute ALU (`a`, `b`, `alu_control`). It sits directly upstream of the ALU. It captures decoded operands, resolves RAW hazards by forwarding from the EX and MEM stages, and detects load-use hazards. It also applies downstream stall and flush requests so that the ALU always sees a coherent, registered operand set.

## Interface
Parameters:
- `DW`, 16, datapath width; must match ALU width.
- `RW`, 3, register-address width (8 registers; r0 reads as zero).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: decode stage presents a valid instruction.
- `rs1_addr`, `rs2_addr`, `rd_addr` in RW: source and destination register numbers.
- `rs1_data`, `rs2_data` in DW: register-file read data.
- `imm` in DW: sign-extended immediate.
- `use_imm` in 1: ALU operand b comes from `imm`, not rs2.
- `alu_ctrl_in` in 3: ALU function select.
- `reg_write_in`, `mem_read_in`, `mem_write_in` in 1: decoded control.
- `stall` in 1: downstream hold request.
- `flush` in 1: kill the instruction being captured (branch taken).
- `alu_result` in DW: ALU output for the instruction currently held in this stage.
- `mem_rd` in RW, `mem_reg_write` in 1, `mem_result` in DW: MEM-stage writeback info.
- `ex_valid` out 1: held instruction is live.
- `ex_a`, `ex_b` out DW: registered ALU operands.
- `ex_alu_control` out 3: registered ALU function select.
- `ex_rd` out RW: registered destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control, gated by valid.
- `ex_store_data` out DW: forwarded rs2 value, for stores.
- `hazard_stall` out 1: combinational; upstream must hold PC and the ID register.

## Operation
- Forwarding is resolved combinationally on the ID-side inputs and is captured into the register.
- For each source `s` in {rs1, rs2}:
  - EX match: `ex_valid && ex_reg_write && !ex_mem_read && ex_rd==s_addr && s_addr!=0` selects `alu_result`.
  - Otherwise MEM match: `mem_reg_write && mem_rd==s_addr && s_addr!=0` selects `mem_result`.
  - Otherwise the source uses `s_data`.
  - EX has priority over MEM.
  - `s_addr==0` always yields 0, regardless of `s_data`.
- Operand mapping: `ex_a` = fwd rs1; `ex_b` = `use_imm ? imm : fwd rs2`; `ex_store_data` = fwd rs2 always.
- Load-use hazard: `hazard_stall = in_valid && ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==rs1_addr || (ex_rd==rs2_addr && (!use_imm || mem_write_in)))`.
- Per-edge update, in priority order:
  1. `!rst_n`: all outputs go to 0.
  2. `flush`: `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` go to 0. Data fields are don't-care but are cleared to 0.
  3. `stall`: every register holds.
  4. `hazard_stall`: insert a bubble. The valid and control bits go to 0; data is cleared.
  5. Otherwise, load: `ex_valid <= in_valid`. Control bits load ANDed with `in_valid`; data loads.
- `flush` overrides `stall`. `stall` suppresses bubble insertion, so the load stays in EX and `hazard_stall` remains asserted.
- `hazard_stall` is not masked by `stall`.
- `ex_alu_control` on a bubble/reset is 3'b000 (add; result 0 with zero operands).

## Timing
- Latency is 1 cycle from ID inputs to `ex_*` outputs.
- `hazard_stall` is combinational from the inputs and the current state, with no registered delay.
- A load-use sequence costs exactly one bubble cycle. On the following cycle the load has moved to MEM and the value is forwarded via `mem_result`.
- Reset mid-stall or mid-hazard: the next edge with `rst_n=0` clears everything, and `hazard_stall` drops because `ex_valid=0`.
- No combinational path from `alu_result` to `hazard_stall`.

## Test plan
- Reset: `rst_n=0` for 2 cycles with random inputs -> all `ex_*`=0 and `hazard_stall`=0; the first edge after release loads normally.
- EX forwarding:
  - Cycle 0: load `add r3` with `alu_result`=0x1234 (`ex_rd`=3, `ex_reg_write`=1).
  - Cycle 1: present `rs1_addr`=3, `rs1_data`=0xDEAD, with `mem_rd`=3 and `mem_result`=0x5555.
  - Expected: `ex_a`=0x1234 (EX beats MEM).
- r0 and immediate:
  - `rs1_addr`=0, `rs1_data`=0xFFFF, with a matching EX write to r0 -> `ex_a`=0.
  - `use_imm`=1, `imm`=0x0007 -> `ex_b`=0x0007, `ex_store_data`= fwd rs2.
- Load-use:
  - EX holds a load to r2; ID reads rs2=r2 with `use_imm`=0.
  - Expected: `hazard_stall`=1 and a bubble the next cycle (`ex_valid`=0).
  - With `mem_rd`=2 and `mem_result`=0x00AB, the retry captures `ex_b`=0x00AB.
- Stall vs flush:
  - `stall`=1 for 3 cycles -> outputs are held bit-exact.
  - `stall`=1 with `flush`=1 -> `ex_valid`=0 and all control bits 0.
- Hazard under stall: load-use condition with `stall`=1 -> registers hold, `hazard_stall` stays 1, and no bubble is inserted until `stall` drops.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, forwarding and execute-side signals of the ID/EX stage
interface id_ex_stage_if #(parameter int DW = 16, parameter int RW = 3);
  logic          in_valid;
  logic [RW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [DW-1:0] rs1_data, rs2_data, imm;
  logic          use_imm;
  logic [2:0]    alu_ctrl_in;
  logic          reg_write_in, mem_read_in, mem_write_in;
  logic          stall, flush;
  logic [DW-1:0] alu_result;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic [DW-1:0] mem_result;
  logic          ex_valid;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [2:0]    ex_alu_control;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;
  logic          hazard_stall;
  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, use_imm,
           alu_ctrl_in, reg_write_in, mem_read_in, mem_write_in, stall, flush,
           alu_result, mem_rd, mem_reg_write, mem_result,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );
  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, use_imm,
           alu_ctrl_in, reg_write_in, mem_read_in, mem_write_in, stall, flush,
           alu_result, mem_rd, mem_reg_write, mem_result,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM operand forwarding and load-use detection
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sd;
    logic [2:0]    alu;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } ex_t;
  ex_t           ex_q, ex_d, ld;
  logic [DW-1:0] fwd1, fwd2;
  logic          ex_fwd_ok, hazard;
  assign ex_fwd_ok = ex_q.v && ex_q.rw && !ex_q.mr;
  assign hazard = bus.in_valid && ex_q.v && ex_q.mr && ex_q.rd != '0 &&
                  (ex_q.rd == bus.rs1_addr ||
                   (ex_q.rd == bus.rs2_addr && (!bus.use_imm || bus.mem_write_in)));
  // operand forwarding: r0 is zero, EX result beats MEM result beats register file
  always_comb begin
    fwd1 = bus.rs1_addr == '0 ? '0
         : (ex_fwd_ok && ex_q.rd == bus.rs1_addr) ? bus.alu_result
         : (bus.mem_reg_write && bus.mem_rd == bus.rs1_addr) ? bus.mem_result
         : bus.rs1_data;
    fwd2 = bus.rs2_addr == '0 ? '0
         : (ex_fwd_ok && ex_q.rd == bus.rs2_addr) ? bus.alu_result
         : (bus.mem_reg_write && bus.mem_rd == bus.rs2_addr) ? bus.mem_result
         : bus.rs2_data;
  end
  // next state: flush or an unstalled load-use bubble clears, stall holds, otherwise capture
  always_comb begin
    ld = '{v: bus.in_valid, a: fwd1, b: bus.use_imm ? bus.imm : fwd2, sd: fwd2,
           alu: bus.alu_ctrl_in, rd: bus.rd_addr,
           rw: bus.reg_write_in && bus.in_valid,
           mr: bus.mem_read_in && bus.in_valid,
           mw: bus.mem_write_in && bus.in_valid};
    ex_d = (bus.flush || (!bus.stall && hazard)) ? '0 : bus.stall ? ex_q : ld;
  end
  // stage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign bus.ex_valid       = ex_q.v;
  assign bus.ex_a           = ex_q.a;
  assign bus.ex_b           = ex_q.b;
  assign bus.ex_store_data  = ex_q.sd;
  assign bus.ex_alu_control = ex_q.alu;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_reg_write   = ex_q.rw;
  assign bus.ex_mem_read    = ex_q.mr;
  assign bus.ex_mem_write   = ex_q.mw;
  assign bus.hazard_stall   = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random stimulus checked against a behavioural ID/EX model
module tb_id_ex_stage;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  id_ex_stage_if b ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(b));
  // model of the instruction sitting in EX
  logic        m_v = 0, m_rw = 0, m_mr = 0, m_mw = 0;
  logic [15:0] m_a = 0, m_b = 0, m_sd = 0;
  logic [2:0]  m_alu = 0, m_rd = 0;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] src(input logic [2:0] addr, input logic [15:0] data);
    if (addr == 0) return 16'h0;
    if (m_v && m_rw && !m_mr && m_rd == addr) return b.alu_result;
    if (b.mem_reg_write && b.mem_rd == addr) return b.mem_result;
    return data;
  endfunction
  function automatic logic m_haz();
    logic uses1, uses2;
    uses1 = (m_rd == b.rs1_addr);
    uses2 = (m_rd == b.rs2_addr) && (!b.use_imm || b.mem_write_in);
    return b.in_valid && m_v && m_mr && m_rd != 0 && (uses1 || uses2);
  endfunction
  always @(posedge clk) begin : model
    logic        h;
    logic [15:0] f1, f2;
    h = m_haz();
    f1 = src(b.rs1_addr, b.rs1_data);
    f2 = src(b.rs2_addr, b.rs2_data);
    if (!rst_n || b.flush) begin
      {m_v, m_rw, m_mr, m_mw, m_a, m_b, m_sd, m_alu, m_rd} = '0;
    end else if (b.stall) begin
    end else if (h) begin
      {m_v, m_rw, m_mr, m_mw, m_a, m_b, m_sd, m_alu, m_rd} = '0;
    end else begin
      m_v = b.in_valid;
      m_rw = b.reg_write_in & b.in_valid;
      m_mr = b.mem_read_in & b.in_valid;
      m_mw = b.mem_write_in & b.in_valid;
      m_a = f1;
      m_b = b.use_imm ? b.imm : f2;
      m_sd = f2;
      m_alu = b.alu_ctrl_in;
      m_rd = b.rd_addr;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("valid", b.ex_valid, m_v);
      chk("a", b.ex_a, m_a);
      chk("b", b.ex_b, m_b);
      chk("store_data", b.ex_store_data, m_sd);
      chk("alu_control", b.ex_alu_control, m_alu);
      chk("rd", b.ex_rd, m_rd);
      chk("reg_write", b.ex_reg_write, m_rw);
      chk("mem_read", b.ex_mem_read, m_mr);
      chk("mem_write", b.ex_mem_write, m_mw);
      chk("hazard_stall", b.hazard_stall, m_haz());
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    b.in_valid = 0; b.rs1_addr = 0; b.rs2_addr = 0; b.rd_addr = 0;
    b.rs1_data = 0; b.rs2_data = 0; b.imm = 0; b.use_imm = 0; b.alu_ctrl_in = 0;
    b.reg_write_in = 0; b.mem_read_in = 0; b.mem_write_in = 0;
    b.stall = 0; b.flush = 0; b.alu_result = 0;
    b.mem_rd = 0; b.mem_reg_write = 0; b.mem_result = 0;
  endtask
  task automatic rnd_in(input int lo_addr_max);
    b.in_valid = 1'($urandom); b.rs1_addr = 3'($urandom_range(0, lo_addr_max));
    b.rs2_addr = 3'($urandom_range(0, lo_addr_max)); b.rd_addr = 3'($urandom_range(0, lo_addr_max));
    b.rs1_data = 16'($urandom); b.rs2_data = 16'($urandom); b.imm = 16'($urandom);
    b.use_imm = 1'($urandom); b.alu_ctrl_in = 3'($urandom);
    b.reg_write_in = 1'($urandom); b.mem_read_in = 1'($urandom); b.mem_write_in = 1'($urandom);
    b.alu_result = 16'($urandom); b.mem_rd = 3'($urandom_range(0, lo_addr_max));
    b.mem_reg_write = 1'($urandom); b.mem_result = 16'($urandom);
    b.stall = ($urandom_range(0, 4) == 0); b.flush = ($urandom_range(0, 9) == 0);
  endtask
  initial begin
    rst_n = 0;
    rnd_in(7);
    cyc();
    armed = 1;
    rnd_in(7);
    cyc();
    chk("rst_valid", b.ex_valid, 1'b0);
    chk("rst_a", b.ex_a, 16'h0);
    chk("rst_hazard", b.hazard_stall, 1'b0);
    clr_in();
    rst_n = 1;
    b.in_valid = 1; b.rd_addr = 3; b.reg_write_in = 1; b.rs1_addr = 1; b.rs1_data = 16'h0005;
    cyc();
    chk("load_rd", b.ex_rd, 16'd3);
    chk("load_rw", b.ex_reg_write, 1'b1);
    chk("load_a", b.ex_a, 16'h0005);
    clr_in();
    b.in_valid = 1; b.alu_result = 16'h1234; b.rs1_addr = 3; b.rs1_data = 16'hDEAD;
    b.mem_rd = 3; b.mem_reg_write = 1; b.mem_result = 16'h5555; b.rd_addr = 4; b.reg_write_in = 1;
    cyc();
    chk("ex_beats_mem", b.ex_a, 16'h1234);
    clr_in();
    b.in_valid = 1; b.rd_addr = 0; b.reg_write_in = 1;
    cyc();
    clr_in();
    b.in_valid = 1; b.rs1_addr = 0; b.rs1_data = 16'hFFFF; b.alu_result = 16'hBEEF;
    b.mem_rd = 0; b.mem_reg_write = 1; b.mem_result = 16'h7777;
    b.use_imm = 1; b.imm = 16'h0007; b.rs2_addr = 5; b.rs2_data = 16'h0042;
    b.rd_addr = 2; b.mem_read_in = 1; b.reg_write_in = 1;
    cyc();
    chk("r0_zero", b.ex_a, 16'h0);
    chk("imm_b", b.ex_b, 16'h0007);
    chk("imm_store", b.ex_store_data, 16'h0042);
    chk("load_mr", b.ex_mem_read, 1'b1);
    clr_in();
    b.in_valid = 1; b.rs2_addr = 2; b.rs1_addr = 1; b.rs1_data = 16'h0010;
    b.rd_addr = 5; b.reg_write_in = 1;
    #1;
    chk("lu_hazard", b.hazard_stall, 1'b1);
    cyc();
    chk("lu_bubble_v", b.ex_valid, 1'b0);
    chk("lu_bubble_rw", b.ex_reg_write, 1'b0);
    b.mem_rd = 2; b.mem_reg_write = 1; b.mem_result = 16'h00AB;
    #1;
    chk("lu_cleared", b.hazard_stall, 1'b0);
    cyc();
    chk("lu_retry_b", b.ex_b, 16'h00AB);
    chk("lu_retry_a", b.ex_a, 16'h0010);
    chk("lu_retry_v", b.ex_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rnd_in(7);
      b.stall = 1; b.flush = 0;
      cyc();
    end
    chk("stall_a", b.ex_a, 16'h0010);
    chk("stall_b", b.ex_b, 16'h00AB);
    chk("stall_rd", b.ex_rd, 16'd5);
    chk("stall_v", b.ex_valid, 1'b1);
    b.stall = 1; b.flush = 1;
    cyc();
    chk("flush_v", b.ex_valid, 1'b0);
    chk("flush_rw", b.ex_reg_write, 1'b0);
    chk("flush_mr", b.ex_mem_read, 1'b0);
    chk("flush_mw", b.ex_mem_write, 1'b0);
    clr_in();
    b.in_valid = 1; b.mem_read_in = 1; b.reg_write_in = 1; b.rd_addr = 6;
    cyc();
    clr_in();
    b.in_valid = 1; b.rs1_addr = 6; b.rd_addr = 7; b.reg_write_in = 1; b.stall = 1;
    #1;
    chk("hs_hazard0", b.hazard_stall, 1'b1);
    cyc();
    cyc();
    chk("hs_rd", b.ex_rd, 16'd6);
    chk("hs_mr", b.ex_mem_read, 1'b1);
    chk("hs_hazard", b.hazard_stall, 1'b1);
    b.stall = 0;
    cyc();
    chk("hs_bubble", b.ex_valid, 1'b0);
    chk("hs_drop", b.hazard_stall, 1'b0);
    clr_in();
    b.in_valid = 1; b.mem_read_in = 1; b.reg_write_in = 1; b.rd_addr = 6;
    cyc();
    clr_in();
    b.in_valid = 1; b.rs2_addr = 6; b.use_imm = 1; b.mem_write_in = 1;
    #1;
    chk("st_hazard", b.hazard_stall, 1'b1);
    rst_n = 0;
    cyc();
    chk("rh_valid", b.ex_valid, 1'b0);
    chk("rh_hazard", b.hazard_stall, 1'b0);
    chk("rh_mr", b.ex_mem_read, 1'b0);
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      rnd_in(3);
      rst_n = ($urandom_range(0, 40) != 0);
      cyc();
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
